mem_access_unit: RTL and testbench

// - MEM stage consumer of the EX/MEM pipeline register; drives the data-memory request/grant/response bus.
// - Holds the pipeline (mem_stall) while a load or store is outstanding, then delivers the result.
// - Formats byte lanes and performs load sign/zero extension.
// - Feeds the MEM/WB register fields (write-back controls, rd, load data, ALU result).

---
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory request/grant/response bus between the MEM stage and the
// data memory.
//   master (MEM stage): req, we, addr, be, wdata out; gnt, rvalid, rdata in
//   slave  (memory)   : the reverse
// A request is accepted in the cycle req & gnt. Load data arrives on a later
// cycle, marked by rvalid.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage. It consumes the EX/MEM register and runs one data-memory
// transaction at a time over dmem. It holds the pipeline with mem_stall while
// that transaction is outstanding. It formats store byte lanes and
// sign/zero-extends load data, and it updates the MEM/WB register fields.
//
// Ports:
//   clock, resetn          rising-edge clock, asynchronous active-low reset
//   flush                  kill the instruction currently in MEM
//   *_in                   EX/MEM fields (ops, WB controls, size, address, data, rd)
//   dmem                   data-memory bus (master side)
//   mem_stall              combinational hold for EX/MEM and earlier stages
//   *_out                  MEM/WB register fields
//   misaligned_out         only with MISALIGN_TRAP_EN: one-cycle trap marker
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses. When it is not defined, the offending low address bits are ignored.
// ADDR_W must be <= 32 (the address comes from alu_result_in).
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic [1:0]        mem_size_in,
    input  logic              mem_unsigned_in,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       alu_in_2_in,
    input  logic [4:0]        reg_rd_in,
    mem_access_unit_if.master dmem,
    output logic              mem_stall,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic [4:0]        reg_rd_out,
    output logic [31:0]       mem_data_out,
`ifdef MISALIGN_TRAP_EN
    output logic              misaligned_out,
`endif
    output logic [31:0]       alu_result_out
);
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

    typedef struct packed {
        logic        mem_to_reg;
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] alu;
    } wb_t;

    state_t      state, state_nxt;
    logic        kill, kill_nxt;
    wb_t         wb_q, wb_nxt;
    logic        op, is_store, misal, req, complete, stall;
    logic [1:0]  o;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;

    assign op       = mem_read_in | mem_write_in;
    assign is_store = mem_write_in;          // store wins when both are set
    assign o        = alu_result_in[1:0];

`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    // Only evaluated in IDLE: a trapped op never starts a transaction.
    assign misal = op && (state == IDLE) &&
                   ((mem_size_in == 2'b01 && o[0]) || (mem_size_in[1] && o != 2'b00));
    assign misaligned_out = mis_q;
`else
    assign misal = 1'b0;
`endif

    // Store lane formatting. Half ignores o[0]; word ignores o entirely.
    assign dmem.addr = {alu_result_in[ADDR_W-1:2], 2'b00};
    assign dmem.we   = is_store;
    always_comb begin
        dmem.be    = 4'b1111;
        dmem.wdata = alu_in_2_in;
        case (mem_size_in)
            2'b00: begin
                dmem.be    = 4'b0001 << o;
                dmem.wdata = {4{alu_in_2_in[7:0]}};
            end
            2'b01: begin
                dmem.be    = 4'b0011 << {o[1], 1'b0};
                dmem.wdata = {2{alu_in_2_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and extension
    assign ld_b = dmem.rdata[{o, 3'b000} +: 8];
    assign ld_h = o[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    always_comb begin
        ld_data = dmem.rdata;
        case (mem_size_in)
            2'b00:   ld_data = mem_unsigned_in ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
            2'b01:   ld_data = mem_unsigned_in ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
            default: ;
        endcase
    end

    // Transaction FSM. Once a request is out it is never withdrawn, even on
    // flush; the flush is remembered in kill and applied at completion.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                req = op & ~flush & ~misal;
                if (req) begin
                    if (!dmem.gnt)    state_nxt = WAIT_GNT;
                    else if (is_store) complete = 1'b1;
                    else               state_nxt = WAIT_RSP;
                end
            end
            WAIT_GNT: begin
                req = 1'b1;
                if (dmem.gnt) begin
                    if (is_store) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (dmem.rvalid) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        stall = (req | (state == WAIT_RSP)) & ~complete;
    end

    assign kill_nxt  = complete ? 1'b0 : (kill | (flush & (state != IDLE)));
    assign dmem.req  = req & resetn;
    assign mem_stall = stall & resetn;

    // MEM/WB: a bubble while stalled, killed or trapped; otherwise the
    // instruction's fields. Only a completing load carries load data.
    always_comb begin
        wb_nxt = '0;
        if (!stall && !kill && !flush && !misal) begin
            wb_nxt.mem_to_reg = mem_to_reg_in;
            wb_nxt.reg_write  = reg_write_in;
            wb_nxt.rd         = reg_rd_in;
            wb_nxt.alu        = alu_result_in;
            wb_nxt.data       = (complete && !is_store) ? ld_data : 32'd0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            kill  <= 1'b0;
            wb_q  <= '0;
`ifdef MISALIGN_TRAP_EN
            mis_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
            wb_q  <= wb_nxt;
`ifdef MISALIGN_TRAP_EN
            mis_q <= misal & ~flush;
`endif
        end
    end

    assign mem_to_reg_out = wb_q.mem_to_reg;
    assign reg_write_out  = wb_q.reg_write;
    assign reg_rd_out     = wb_q.rd;
    assign mem_data_out   = wb_q.data;
    assign alu_result_out = wb_q.alu;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    logic        flush, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, mem_unsigned_in;
    logic [1:0]  mem_size_in;
    logic [31:0] alu_result_in, alu_in_2_in;
    logic [4:0]  reg_rd_in;
    logic        mem_stall, mem_to_reg_out, reg_write_out, mis_out;
    logic [4:0]  reg_rd_out;
    logic [31:0] mem_data_out, alu_result_out;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    // Memory side: either hand-driven (directed part) or the slave model
    logic        auto_slv = 1'b0;
    logic        s_gnt = 1'b0, s_rvalid = 1'b0, m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [31:0] s_rdata = '0, m_rdata = '0;
    assign bus.gnt    = auto_slv ? s_gnt    : m_gnt;
    assign bus.rvalid = auto_slv ? s_rvalid : m_rvalid;
    assign bus.rdata  = auto_slv ? s_rdata  : m_rdata;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clock(clock), .resetn(resetn), .flush(flush),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
        .alu_result_in(alu_result_in), .alu_in_2_in(alu_in_2_in), .reg_rd_in(reg_rd_in),
        .dmem(bus), .mem_stall(mem_stall),
        .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .reg_rd_out(reg_rd_out), .mem_data_out(mem_data_out),
`ifdef MISALIGN_TRAP_EN
        .misaligned_out(mis_out),
`endif
        .alu_result_out(alu_result_out)
    );
`ifndef MISALIGN_TRAP_EN
    assign mis_out = 1'b0;
`endif

    typedef struct { logic rw, m2r, mis; logic [4:0] rd; logic [31:0] data, alu; } wb_t;
    typedef struct { logic we; logic [31:0] addr, wdata; logic [3:0] be; } rq_t;

    wb_t         exp_q[$];
    rq_t         req_q[$];
    logic [31:0] ref_mem[16];
    logic [31:0] smem[16];
    int          total = 0, bad = 0;
    int          gnt_dly = 0, rsp_dly = 1;
    logic        mon_en = 1'b0, init_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Slave memory: grants after gnt_dly request cycles, returns load data
    // rsp_dly cycles after the grant, and checks every accepted request.
    initial begin : slave
        int          req_cyc, rsp_cnt;
        logic [31:0] rword;
        logic [3:0]  sidx;
        rq_t         e;
        req_cyc = 0; rsp_cnt = 0; rword = '0;
        wait (init_done);
        foreach (smem[i]) smem[i] = ref_mem[i];
        forever begin
            @(negedge clock);
            s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = $urandom;
            if (!resetn || !auto_slv) begin
                req_cyc = 0; rsp_cnt = 0;
            end else if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin s_rvalid = 1'b1; s_rdata = rword; end
            end else if (bus.req) begin
                if (req_cyc < gnt_dly) req_cyc++;
                else begin
                    s_gnt = 1'b1; req_cyc = 0;
                    total++;
                    if (req_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_req got addr=%h want none", bus.addr);
                    end else begin
                        e = req_q.pop_front();
                        if (bus.we !== e.we || bus.addr !== e.addr || bus.be !== e.be ||
                            (e.we && ((bus.wdata & lane_mask(e.be)) !== (e.wdata & lane_mask(e.be))))) begin
                            bad++;
                            $display("FAIL req got we=%0d addr=%h be=%h wdata=%h want we=%0d addr=%h be=%h wdata=%h",
                                     bus.we, bus.addr, bus.be, bus.wdata, e.we, e.addr, e.be, e.wdata);
                        end
                    end
                    sidx = bus.addr[5:2];
                    if (bus.we) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.be[b]) smem[sidx][8*b +: 8] = bus.wdata[8*b +: 8];
                    end else begin
                        rword = smem[sidx]; rsp_cnt = rsp_dly;
                    end
                end
            end
        end
    end

    // Monitor: every cycle the stage advances (no stall), the MEM/WB fields
    // after the edge must match the oldest expected record.
    initial begin : monitor
        logic adv;
        wb_t  e;
        forever begin
            @(negedge clock); #2;
            adv = mon_en && resetn && !mem_stall;
            @(posedge clock); #1;
            if (adv) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wb_underflow got rw=%0d want none", reg_write_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({reg_write_out, mem_to_reg_out, mis_out, reg_rd_out, mem_data_out, alu_result_out} !==
                        {e.rw, e.m2r, e.mis, e.rd, e.data, e.alu}) begin
                        bad++;
                        $display("FAIL wb got rw=%0d m2r=%0d mis=%0d rd=%0d data=%h alu=%h want rw=%0d m2r=%0d mis=%0d rd=%0d data=%h alu=%h",
                                 reg_write_out, mem_to_reg_out, mis_out, reg_rd_out, mem_data_out, alu_result_out,
                                 e.rw, e.m2r, e.mis, e.rd, e.data, e.alu);
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        flush = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
        reg_write_in = 1'b0; mem_unsigned_in = 1'b0; mem_size_in = 2'b00;
        alu_result_in = '0; alu_in_2_in = '0; reg_rd_in = '0;
    endtask

    initial begin : main
        int          kind, fmode, cyc, stalls, exp_stalls, nb, sh;
        logic [1:0]  o, eo;
        logic [3:0]  idx;
        logic [31:0] v, msk;
        logic        ld, st, trap, issue, flushed, abort;
        wb_t         e;
        rq_t         r;
        abort = 1'b0;
        clear_inputs();
        foreach (ref_mem[i]) ref_mem[i] = $urandom;
        init_done = 1'b1;

        // Reset: load presented with gnt while resetn is low
        repeat (2) @(posedge clock); #1;
        mem_read_in = 1'b1; alu_result_in = 32'h103; reg_rd_in = 5'd5;
        reg_write_in = 1'b1; mem_to_reg_in = 1'b1; m_gnt = 1'b1;
        #1;
        chk("rst_req", 32'(bus.req), 0);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_rw", 32'(reg_write_out), 0);
        chk("rst_rd", 32'(reg_rd_out), 0);
        chk("rst_data", mem_data_out, 0);
        chk("rst_alu", alu_result_out, 0);
        resetn = 1'b1; #1;
        chk("ld_req", 32'(bus.req), 1);
        chk("ld_be", 32'(bus.be), 32'h8);
        chk("ld_stall", 32'(mem_stall), 1);
        @(posedge clock); #1;
        m_gnt = 1'b0; #1;
        chk("wrsp_req", 32'(bus.req), 0);
        chk("wrsp_stall", 32'(mem_stall), 1);
        chk("wrsp_bubble", 32'(reg_write_out), 0);
        // Reset during WAIT_RSP, then a late rvalid
        resetn = 1'b0; clear_inputs(); m_rvalid = 1'b1; m_rdata = 32'h8000_0000; #1;
        chk("rst2_stall", 32'(mem_stall), 0);
        @(posedge clock); #1 resetn = 1'b1;
        @(posedge clock); #1 m_rvalid = 1'b0;
        chk("rst2_rw", 32'(reg_write_out), 0);
        chk("rst2_data", mem_data_out, 0);
        chk("rst2_rd", 32'(reg_rd_out), 0);
        // Word store with same-cycle grant: no stall proves FSM is back in IDLE
        mem_write_in = 1'b1; mem_size_in = 2'b10; alu_result_in = 32'h100;
        alu_in_2_in = 32'hDEAD_BEEF; m_gnt = 1'b1; #1;
        chk("st_req", 32'(bus.req), 1);
        chk("st_we", 32'(bus.we), 1);
        chk("st_addr", bus.addr, 32'h100);
        chk("st_be", 32'(bus.be), 32'hF);
        chk("st_wdata", bus.wdata, 32'hDEAD_BEEF);
        chk("st_stall", 32'(mem_stall), 0);
        @(posedge clock); #1;
        chk("st_alu", alu_result_out, 32'h100);
        m_gnt = 1'b0; clear_inputs();
        @(posedge clock); #1;

        // Randomized phase against the reference model
        auto_slv = 1'b1; mon_en = 1'b1;
        for (int n = 0; n < 400 && !abort; n++) begin
            kind = $urandom_range(0, 9);
            mem_read_in     = (kind <= 3) || (kind == 8);
            mem_write_in    = (kind >= 4) && (kind <= 8);
            mem_size_in     = 2'($urandom_range(0, 3));
            mem_unsigned_in = 1'($urandom_range(0, 1));
            reg_write_in    = 1'($urandom_range(0, 1));
            mem_to_reg_in   = 1'($urandom_range(0, 1));
            reg_rd_in       = 5'($urandom_range(0, 31));
            alu_in_2_in     = $urandom;
            idx = 4'($urandom_range(0, 15));
            o   = 2'($urandom_range(0, 3));
            alu_result_in = (kind == 9) ? $urandom : (32'h200 + 32'(idx) * 4 + 32'(o));
            gnt_dly = $urandom_range(0, 3);
            rsp_dly = $urandom_range(1, 3);
            fmode   = $urandom_range(0, 7);   // 0: flush first cycle, 1: flush later cycles

            st = mem_write_in;
            ld = mem_read_in & ~mem_write_in;
            nb = (mem_size_in == 2'b00) ? 1 : (mem_size_in == 2'b01) ? 2 : 4;
            trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
            trap = (ld | st) && (32'(o) % nb != 0);
`endif
            issue = (ld | st) && (fmode != 0) && !trap;
            // Effective offset: access aligned down to its own size
            eo  = 2'(32'(o) - (32'(o) % nb));
            sh  = 8 * int'(eo);
            msk = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
            v   = '0;
            if (issue) begin
                r.we = st; r.addr = alu_result_in & ~32'h3;
                r.be = 4'(((1 << nb) - 1) << int'(eo));
                r.wdata = alu_in_2_in << sh;
                req_q.push_back(r);
                if (st) ref_mem[idx] = (ref_mem[idx] & ~(msk << sh)) | ((alu_in_2_in & msk) << sh);
                else begin
                    v = (ref_mem[idx] >> sh) & msk;
                    if (!mem_unsigned_in && nb < 4 && v[8*nb-1]) v = v | ~msk;
                end
            end
            exp_stalls = !issue ? 0 : st ? gnt_dly : gnt_dly + rsp_dly;

            cyc = 0; stalls = 0; flushed = 1'b0;
            forever begin
                flush = (fmode == 0 && cyc == 0) || (fmode == 1 && cyc > 0);
                flushed = flushed | flush;
                @(negedge clock); #1;
                if (!mem_stall) break;
                stalls++; cyc++;
                if (cyc > 40) begin
                    total++; bad++; abort = 1'b1;
                    $display("FAIL stall_timeout got stalls=%0d want %0d", stalls, exp_stalls);
                    break;
                end
                @(posedge clock); #1;
            end
            if (abort) break;
            chk("stall_cycles", 32'(stalls), 32'(exp_stalls));

            e.rw = 1'b0; e.m2r = 1'b0; e.rd = '0; e.data = '0; e.alu = '0;
            e.mis = trap && !flushed;
            if (!flushed && !trap) begin
                e.rw = reg_write_in; e.m2r = mem_to_reg_in; e.rd = reg_rd_in;
                e.alu = alu_result_in; e.data = ld ? v : 32'd0;
            end
            exp_q.push_back(e);
            @(posedge clock); #1;
        end
        clear_inputs();
        mon_en = 1'b0;
        repeat (3) @(posedge clock); #1;
        chk("wb_queue_drained", 32'(exp_q.size()), 0);
        chk("req_queue_drained", 32'(req_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
